booth_div: RTL
==============

Name: booth_div

Overview:
- Sequential signed integer divider; the inverse operation of booth_mult, sharing its en/done handshake.
- Computes A / B with quotient truncated toward zero and remainder carrying the dividend's sign.
- One radix-2 restoring step per clock on operand magnitudes, followed by sign fix-up.
- Sits beside booth_mult in the arithmetic lab datapath; driven by the same style of sweep bench.

Parameters:
- width, 8, operand/result width in bits (signed two's complement); legal range 4..32

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, synchronous, active-high
- en  input  1  request; sampled in IDLE to start, held high until done seen
- A  input  width  signed dividend, sampled on the start edge only
- B  input  width  signed divisor, sampled on the start edge only
- done  output  1  result valid; held high until en drops
- Q  output  width  signed quotient
- R  output  width  signed remainder
- div0  output  1  divisor was zero; valid while done
- ovf  output  1  quotient overflow (most-negative / -1); valid while done

Behaviour:
- Single clock (clk). Reset is synchronous, active-high (rst): sampled on the rising edge of clk only.
- Reset values: done=0, Q=0, R=0, div0=0, ovf=0, state=IDLE, counter=0.
- rst high at any edge, including mid-CALC or in DONE, aborts the operation. Outputs return to reset values on that edge.
- States: IDLE, CALC, FIX, DONE.
- IDLE, when en=1 on the start edge:
  - latch sign_q = A[msb]^B[msb] and sign_r = A[msb];
  - take the magnitudes |A| and |B| as (width+1)-bit unsigned, so -2^(width-1) is representable;
  - clear the partial remainder, load the count = width, go to CALC.
- IDLE, when en=0: stay in IDLE.
- CALC, once per cycle:
  - shift {rem, dividend} left 1;
  - trial subtract |B|; if the result is non-negative, keep it and set quotient bit=1, else restore and set 0;
  - decrement the count; at count=0 go to FIX.
- FIX: apply the signs.
  - Q = sign_q ? -qmag : qmag, truncated to width bits.
  - R = sign_r ? -rmag : rmag.
  - ovf = (A == -2^(width-1)) && (B == -1); in that case Q wraps to -2^(width-1) and R = 0.
  - Then go to DONE.
- DONE: done=1; Q/R/div0/ovf are held stable. When en=0 the next edge clears done and goes to IDLE. en held high keeps DONE, so there is no auto-restart.
- Latency: start edge k; done rises after edge k+width+2 (10 cycles for width=8).
- Divide by zero (B=0): div0=1, Q = all ones (-1), R = A, ovf=0. Timing follows the optional feature below.
- A and B changing while busy has no effect; the latched copies are used.
- A new start is accepted only from IDLE. The minimum request-to-request spacing is latency + 1 cycle (en low for one edge).

Optional Feature:
- Macro: BOOTH_DIV_ZERO_FAST_EN.
- Defined: B=0 on the start edge bypasses CALC/FIX and enters DONE directly. done rises after edge k+1.
- Undefined: B=0 runs the full CALC/FIX sequence with identical latency (width+2). The final results are forced to Q=-1, R=A, div0=1.
- Results are identical in both builds; only the latency differs.

Test Plan:
- Reset mid-CALC: start A=100, B=7, assert rst for 1 cycle at cycle 4 -> next edge done=0, Q=0, R=0, state IDLE; the following request completes normally.
- Sign quadrants, width=8:
  - 100/7 -> Q=14, R=2
  - -100/7 -> Q=-14, R=-2
  - 100/-7 -> Q=-14, R=2
  - -100/-7 -> Q=14, R=-2
  - all with done after exactly 10 cycles, div0=0, ovf=0.
- Overflow: A=-128, B=-1 -> Q=-128, R=0, ovf=1, div0=0.
- Edge magnitudes: A=-128, B=1 -> Q=-128, R=0, ovf=0; A=127, B=-128 -> Q=0, R=127; A=-128, B=-128 -> Q=1, R=0.
- Divide by zero, A=5, B=0 -> Q=-1, R=5, div0=1. done arrives after 1 cycle with BOOTH_DIV_ZERO_FAST_EN, after 10 cycles without.
- Handshake/exhaustive:
  - hold en high after done -> done stays 1, no restart; drop en -> done=0 next edge.
  - full sweep of A, B in -128..127 with B≠0 -> A == Q*B + R, |R| < |B|, sign(R) = sign(A) or R=0.

Source files
------------

// File: rtl/booth_div.sv
// rtl/booth_div.sv - sequential signed restoring divider (Q = A / B toward zero, R with sign of A)
// Optional macro BOOTH_DIV_ZERO_FAST_EN: divide-by-zero skips CALC/FIX and finishes one cycle after start.
module booth_div #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  output logic             done,
  output logic [width-1:0] Q,
  output logic [width-1:0] R,
  output logic             div0,
  output logic             ovf
);
  localparam int CW = $clog2(width + 1);
  localparam logic [width-1:0] MIN_VAL = {1'b1, {(width-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_n;

  logic [CW-1:0]    count;
  logic [width-1:0] rem, dvd, bmag, a_lat;
  logic             sign_q, sign_r, zero_lat, ovf_lat;
  logic [width-1:0] amag_in, bmag_in, diff;
  logic [width:0]   rem_sh;
  logic             ge, b_zero, min_by_neg1;

  // Magnitudes fit unsigned in width bits, including 2^(width-1).
  assign amag_in     = A[width-1] ? -A : A;
  assign bmag_in     = B[width-1] ? -B : B;
  assign b_zero      = (B == '0);
  assign min_by_neg1 = (A == MIN_VAL) && (B == '1);

  assign rem_sh = {rem, dvd[width-1]};
  assign ge     = rem_sh >= {1'b0, bmag};
  assign diff   = rem_sh[width-1:0] - bmag;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (en) begin
`ifdef BOOTH_DIV_ZERO_FAST_EN
        state_n = b_zero ? DONE : CALC;
`else
        state_n = CALC;
`endif
      end
      CALC:    if (count == CW'(1)) state_n = FIX;
      FIX:     state_n = DONE;
      DONE:    if (!en) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      rem      <= '0;
      dvd      <= '0;
      bmag     <= '0;
      a_lat    <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      zero_lat <= 1'b0;
      ovf_lat  <= 1'b0;
      done     <= 1'b0;
      Q        <= '0;
      R        <= '0;
      div0     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      // done trails DONE entry by one edge and drops on the edge that sees en low.
      done <= (state == DONE) && en;
      case (state)
        IDLE: if (en) begin
          sign_q   <= A[width-1] ^ B[width-1];
          sign_r   <= A[width-1];
          dvd      <= amag_in;
          bmag     <= bmag_in;
          rem      <= '0;
          count    <= CW'(width);
          a_lat    <= A;
          zero_lat <= b_zero;
          ovf_lat  <= min_by_neg1;
`ifdef BOOTH_DIV_ZERO_FAST_EN
          if (b_zero) begin
            Q    <= '1;
            R    <= A;
            div0 <= 1'b1;
            ovf  <= 1'b0;
          end
`endif
        end
        CALC: begin
          rem   <= ge ? diff : rem_sh[width-1:0];
          dvd   <= {dvd[width-2:0], ge};
          count <= count - CW'(1);
        end
        FIX: begin
          if (zero_lat) begin
            Q    <= '1;
            R    <= a_lat;
            div0 <= 1'b1;
            ovf  <= 1'b0;
          end else begin
            // Most-negative / -1 wraps naturally: qmag = 2^(width-1), positive sign.
            Q    <= sign_q ? -dvd : dvd;
            R    <= sign_r ? -rem : rem;
            div0 <= 1'b0;
            ovf  <= ovf_lat;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
